// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM-stage bundle, holds on stall, bubbles on flush,
// aligns/extends load data from the registered raw word and counts retired instructions.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [2:0]  mem_rf_wsel,
  input  logic        mem_rf_nwe,
  input  logic [4:0]  mem_rf_waddr,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_rs,
  input  logic [31:0] mem_ram_rdata,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_addr_lo,
  input  logic [63:0] mem_hilo,
  input  logic [31:0] mem_cp0,
  input  logic        mem_cp0_ex,
  input  logic        int_flush_in,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [2:0]  wb_rf_wsel,
  output logic        wb_rf_nwe,
  output logic [4:0]  wb_rf_waddr,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_rs,
  output logic [63:0] wb_hilo,
  output logic [31:0] wb_cp0,
  output logic        wb_cp0_ex,
  output logic        wb_int_flush,
  output logic [31:0] wb_ram,
  output logic [31:0] retire_cnt
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [31:0] ram_raw_r;
  logic [2:0]  load_type_r;
  logic [1:0]  addr_lo_r;
  logic        retire_s;

  // Unrecognised load types fall back to a full-word load.
  function automatic logic [31:0] align_load(input logic [31:0] raw,
                                             input logic [2:0]  lt,
                                             input logic [1:0]  lo);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (lo)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      2'd3:    byte_v = raw[31:24];
      default: byte_v = raw[7:0];
    endcase
    half_v = lo[1] ? raw[31:16] : raw[15:0];
    case (lt)
      LT_LB:   align_load = {{24{byte_v[7]}}, byte_v};
      LT_LBU:  align_load = {24'd0, byte_v};
      LT_LH:   align_load = {{16{half_v[15]}}, half_v};
      LT_LHU:  align_load = {16'd0, half_v};
      default: align_load = raw;
    endcase
  endfunction

  assign retire_s = ~flush & ~stall & mem_valid & ~mem_cp0_ex & ~int_flush_in;

  // Pipeline register: flush beats stall, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_pc        <= 32'd0;
      wb_rf_wsel   <= 3'd0;
      wb_rf_nwe    <= 1'b0;
      wb_rf_waddr  <= 5'd0;
      wb_alu       <= 32'd0;
      wb_rs        <= 32'd0;
      wb_hilo      <= 64'd0;
      wb_cp0       <= 32'd0;
      wb_cp0_ex    <= 1'b0;
      wb_int_flush <= 1'b0;
      ram_raw_r    <= 32'd0;
      load_type_r  <= 3'd0;
      addr_lo_r    <= 2'd0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_pc        <= 32'd0;
      wb_rf_wsel   <= 3'd0;
      wb_rf_nwe    <= 1'b0;
      wb_rf_waddr  <= 5'd0;
      wb_alu       <= 32'd0;
      wb_rs        <= 32'd0;
      wb_hilo      <= 64'd0;
      wb_cp0       <= 32'd0;
      wb_cp0_ex    <= 1'b0;
      wb_int_flush <= 1'b0;
      ram_raw_r    <= 32'd0;
      load_type_r  <= 3'd0;
      addr_lo_r    <= 2'd0;
    end else if (!stall) begin
      wb_valid     <= mem_valid;
      wb_pc        <= mem_pc;
      wb_rf_wsel   <= mem_rf_wsel;
      wb_rf_nwe    <= mem_rf_nwe;
      wb_rf_waddr  <= mem_rf_waddr;
      wb_alu       <= mem_alu;
      wb_rs        <= mem_rs;
      wb_hilo      <= mem_hilo;
      wb_cp0       <= mem_cp0;
      wb_cp0_ex    <= mem_cp0_ex;
      wb_int_flush <= int_flush_in;
      ram_raw_r    <= mem_ram_rdata;
      load_type_r  <= mem_load_type;
      addr_lo_r    <= mem_addr_lo;
    end
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 32'd0;
    end else if (retire_s) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // Load alignment works only from registered copies, so no mem_* path reaches wb_ram.
  always_comb begin
    wb_ram = align_load(ram_raw_r, load_type_r, addr_lo_r);
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table for load alignment plus
// hand-written stall/flush/exception/wrap/reset sequences, checked via a scoreboard queue.
module tb_mem_wb_stage;

  logic        clk, rst_n, stall, flush, mem_valid, mem_rf_nwe, mem_cp0_ex, int_flush_in;
  logic [31:0] mem_pc, mem_alu, mem_rs, mem_ram_rdata, mem_cp0;
  logic [2:0]  mem_rf_wsel, mem_load_type;
  logic [4:0]  mem_rf_waddr;
  logic [1:0]  mem_addr_lo;
  logic [63:0] mem_hilo;
  logic        wb_valid, wb_rf_nwe, wb_cp0_ex, wb_int_flush;
  logic [31:0] wb_pc, wb_alu, wb_rs, wb_cp0, wb_ram, retire_cnt;
  logic [2:0]  wb_rf_wsel;
  logic [4:0]  wb_rf_waddr;
  logic [63:0] wb_hilo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  wsel;
    logic        nwe;
    logic [4:0]  waddr;
    logic [31:0] alu, rs;
    logic [63:0] hilo;
    logic [31:0] cp0;
    logic        cp0_ex, intf;
    logic [31:0] ram, cnt;
  } exp_t;

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] raw;
    logic [31:0] exp_ram;
  } vec_t;

  exp_t model_s;
  exp_t sb_q[$];
  vec_t vecs[12];

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_rf_wsel(mem_rf_wsel),
    .mem_rf_nwe(mem_rf_nwe), .mem_rf_waddr(mem_rf_waddr), .mem_alu(mem_alu),
    .mem_rs(mem_rs), .mem_ram_rdata(mem_ram_rdata), .mem_load_type(mem_load_type),
    .mem_addr_lo(mem_addr_lo), .mem_hilo(mem_hilo), .mem_cp0(mem_cp0),
    .mem_cp0_ex(mem_cp0_ex), .int_flush_in(int_flush_in),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_wsel(wb_rf_wsel), .wb_rf_nwe(wb_rf_nwe),
    .wb_rf_waddr(wb_rf_waddr), .wb_alu(wb_alu), .wb_rs(wb_rs), .wb_hilo(wb_hilo),
    .wb_cp0(wb_cp0), .wb_cp0_ex(wb_cp0_ex), .wb_int_flush(wb_int_flush),
    .wb_ram(wb_ram), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, e.valid});
    chk("wb_pc", {32'd0, wb_pc}, {32'd0, e.pc});
    chk("wb_rf_wsel", {61'd0, wb_rf_wsel}, {61'd0, e.wsel});
    chk("wb_rf_nwe", {63'd0, wb_rf_nwe}, {63'd0, e.nwe});
    chk("wb_rf_waddr", {59'd0, wb_rf_waddr}, {59'd0, e.waddr});
    chk("wb_alu", {32'd0, wb_alu}, {32'd0, e.alu});
    chk("wb_rs", {32'd0, wb_rs}, {32'd0, e.rs});
    chk("wb_hilo", wb_hilo, e.hilo);
    chk("wb_cp0", {32'd0, wb_cp0}, {32'd0, e.cp0});
    chk("wb_cp0_ex", {63'd0, wb_cp0_ex}, {63'd0, e.cp0_ex});
    chk("wb_int_flush", {63'd0, wb_int_flush}, {63'd0, e.intf});
    chk("wb_ram", {32'd0, wb_ram}, {32'd0, e.ram});
    chk("retire_cnt", {32'd0, retire_cnt}, {32'd0, e.cnt});
  endtask

  task automatic clear_model();
    model_s = '{valid: 1'b0, pc: 32'd0, wsel: 3'd0, nwe: 1'b0, waddr: 5'd0, alu: 32'd0,
                rs: 32'd0, hilo: 64'd0, cp0: 32'd0, cp0_ex: 1'b0, intf: 1'b0,
                ram: 32'd0, cnt: 32'd0};
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [2:0] lt,
                        input logic [1:0] lo, input logic [31:0] raw, input logic ex,
                        input logic intf);
    mem_valid     = v;
    mem_pc        = pc;
    mem_load_type = lt;
    mem_addr_lo   = lo;
    mem_ram_rdata = raw;
    mem_cp0_ex    = ex;
    int_flush_in  = intf;
    mem_rf_nwe    = 1'b1;
    mem_rf_wsel   = 3'($urandom_range(1, 7));
    mem_rf_waddr  = 5'($urandom);
    mem_alu       = $urandom;
    mem_rs        = $urandom;
    mem_hilo      = {$urandom, $urandom};
    mem_cp0       = $urandom;
  endtask

  // Advance the model with the current inputs, push the expectation, clock, pop and compare.
  task automatic step(input logic st, input logic fl, input logic [31:0] exp_ram);
    exp_t e;
    stall = st;
    flush = fl;
    if (fl) begin
      model_s = '{valid: 1'b0, pc: 32'd0, wsel: 3'd0, nwe: 1'b0, waddr: 5'd0, alu: 32'd0,
                  rs: 32'd0, hilo: 64'd0, cp0: 32'd0, cp0_ex: 1'b0, intf: 1'b0,
                  ram: 32'd0, cnt: model_s.cnt};
    end else if (!st) begin
      model_s.valid  = mem_valid;
      model_s.pc     = mem_pc;
      model_s.wsel   = mem_rf_wsel;
      model_s.nwe    = mem_rf_nwe;
      model_s.waddr  = mem_rf_waddr;
      model_s.alu    = mem_alu;
      model_s.rs     = mem_rs;
      model_s.hilo   = mem_hilo;
      model_s.cp0    = mem_cp0;
      model_s.cp0_ex = mem_cp0_ex;
      model_s.intf   = int_flush_in;
      model_s.ram    = exp_ram;
      if (mem_valid && !mem_cp0_ex && !int_flush_in) model_s.cnt = model_s.cnt + 32'd1;
    end
    sb_q.push_back(model_s);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      compare_all(e);
    end
  endtask

  initial begin
    logic [31:0] cnt_base;

    vecs[0]  = '{3'b001, 2'd1, 32'h8081_7F02, 32'h0000_007F};
    vecs[1]  = '{3'b001, 2'd3, 32'h8081_7F02, 32'hFFFF_FF80};
    vecs[2]  = '{3'b010, 2'd3, 32'h8081_7F02, 32'h0000_0080};
    vecs[3]  = '{3'b001, 2'd2, 32'h8081_7F02, 32'hFFFF_FF81};
    vecs[4]  = '{3'b010, 2'd0, 32'h8081_7F02, 32'h0000_0002};
    vecs[5]  = '{3'b011, 2'd2, 32'h9234_5678, 32'hFFFF_9234};
    vecs[6]  = '{3'b100, 2'd2, 32'h9234_5678, 32'h0000_9234};
    vecs[7]  = '{3'b011, 2'd0, 32'h9234_5678, 32'h0000_5678};
    vecs[8]  = '{3'b011, 2'd3, 32'h9234_5678, 32'hFFFF_9234};
    vecs[9]  = '{3'b100, 2'd1, 32'h9234_5678, 32'h0000_5678};
    vecs[10] = '{3'b000, 2'd3, 32'h9234_5678, 32'h9234_5678};
    vecs[11] = '{3'b110, 2'd1, 32'h8081_7F02, 32'h8081_7F02};

    // Reset held with random inputs
    rst_n = 1'b0;
    stall = 1'($urandom);
    flush = 1'($urandom);
    set_in(1'b1, $urandom, 3'($urandom), 2'($urandom), $urandom, 1'b1, 1'b1);
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      compare_all(model_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all(model_s);

    // Load alignment vectors
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 32'h100 + 32'(i * 4), vecs[i].lt, vecs[i].lo, vecs[i].raw, 1'b0, 1'b0);
      step(1'b0, 1'b0, vecs[i].exp_ram);
    end

    // Stall for three cycles, then capture the waiting instruction
    set_in(1'b1, 32'h1000, 3'b000, 2'd0, 32'hAAAA_5555, 1'b0, 1'b0);
    cnt_base = model_s.cnt;
    step(1'b0, 1'b0, 32'hAAAA_5555);
    set_in(1'b1, 32'h1004, 3'b000, 2'd0, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h1234_5678);
      chk("stall_pc_frozen", {32'd0, wb_pc}, 64'h1000);
    end
    step(1'b0, 1'b0, 32'h1234_5678);
    chk("stall_pc_after", {32'd0, wb_pc}, 64'h1004);
    chk("stall_retire_delta", {32'd0, retire_cnt - cnt_base}, 64'd2);

    // Flush together with stall
    set_in(1'b1, 32'h2000, 3'b000, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cnt_base = model_s.cnt;
    step(1'b1, 1'b1, 32'd0);
    chk("flush_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_nwe", {63'd0, wb_rf_nwe}, 64'd0);
    chk("flush_retire_hold", {32'd0, retire_cnt}, {32'd0, cnt_base});
    step(1'b0, 1'b0, 32'hDEAD_BEEF);

    // Exception and interrupt pass-through without retiring
    set_in(1'b1, 32'h3000, 3'b000, 2'd0, 32'h0BAD_F00D, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0BAD_F00D);
    set_in(1'b1, 32'h3004, 3'b010, 2'd1, 32'h0000_FF00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0000_00FF);
    set_in(1'b0, 32'h3008, 3'b000, 2'd0, 32'h5555_AAAA, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h5555_AAAA);

    // Counter wrap
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #2;
    release dut.retire_cnt;
    model_s.cnt = 32'hFFFF_FFFF;
    set_in(1'b1, 32'h4000, 3'b000, 2'd0, 32'h7777_8888, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h7777_8888);
    chk("wrap_zero", {32'd0, retire_cnt}, 64'd0);

    // Asynchronous reset during a stall
    set_in(1'b1, 32'h5000, 3'b000, 2'd0, 32'h1111_2222, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h1111_2222);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    compare_all(model_s);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 32'h6000, 3'b011, 2'd2, 32'h8000_0001, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'hFFFF_8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
